lap_stopwatch: RTL and testbench

Parametrised lap-timing stopwatch core. It counts elapsed time in BCD at a tick rate derived from the system clock. It records up to LAPS lap durations in an internal buffer, tracks the best (shortest) lap, and drives a BCD display word for the board-level seven-segment decoders. It sits between the debounced pushbutton/switch pulses and the per-digit seven-segment encoders. It replaces the fixed 4-digit start/stop/best-time controller and its datapath pair with a single block.

---
 rtl/lap_stopwatch.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD lap-timing stopwatch core.
// It keeps a running total and a per-lap time, stores up to LAPS lap
// durations, and tracks the shortest lap. All outputs come from registers.
// The display word is computed from next-state values and registered, so it
// changes on the same edge as its source.

module lap_stopwatch #(
    parameter int DIGITS   = 4,
    parameter int LAPS     = 8,
    parameter int TICK_DIV = 500000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         lap,
    input  logic                         recall,
    input  logic                         clear,
    output logic [4*DIGITS-1:0]          show,
    output logic [1:0]                   state,
    output logic [$clog2(LAPS+1)-1:0]    lap_count,
    output logic [$clog2(LAPS+1)-1:0]    view_idx,
    output logic                         best_valid,
    output logic                         lap_full,
    output logic                         overflow
);

    localparam int W     = 4 * DIGITS;
    localparam int CW    = $clog2(LAPS + 1);
    localparam int PW    = $clog2(TICK_DIV);
    // Buffer index width; the buffer is rounded up to a power of two so that
    // an IW-bit index can never select outside it.
    localparam int IW    = (LAPS > 1) ? $clog2(LAPS) : 1;
    localparam int DEPTH = 1 << IW;

    localparam logic [CW-1:0] LAPS_C  = CW'(LAPS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZRO = {CW{1'b0}};
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [PW-1:0] PRE_ZRO = {PW{1'b0}};
    localparam logic [W-1:0]  BCD_ZRO = {W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2,
        ST_RECALL  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_CLEAR  = 3'd1,
        CMD_STOP   = 3'd2,
        CMD_START  = 3'd3,
        CMD_LAP    = 3'd4,
        CMD_RECALL = 3'd5
    } cmd_t;

    // True when every BCD digit of v is 9 (the saturation value).
    function automatic logic bcd_all9(input logic [W-1:0] v);
        logic all;
        all = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            all = all & (v[4*k +: 4] == 4'd9);
        end
        return all;
    endfunction

    // Saturating BCD increment with per-digit 9->0 carry.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        if (bcd_all9(v)) begin
            r = v;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (carry) begin
                    if (v[4*k +: 4] == 4'd9) begin
                        r[4*k +: 4] = 4'd0;
                        carry       = 1'b1;
                    end else begin
                        r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[4*k +: 4] = v[4*k +: 4];
                end
            end
        end
        return r;
    endfunction

    // Registers
    state_t          state_r;
    logic [PW-1:0]   presc_r;
    logic [W-1:0]    total_r;
    logic [W-1:0]    lapt_r;
    logic [W-1:0]    best_r;
    logic            best_valid_r;
    logic [CW-1:0]   lap_count_r;
    logic [CW-1:0]   view_r;
    logic            overflow_r;
    logic            lap_full_r;
    logic [W-1:0]    show_r;
    logic [W-1:0]    buf_r [DEPTH];

    // Next-state signals
    state_t          state_nxt_s;
    logic [PW-1:0]   presc_nxt_s;
    logic [W-1:0]    total_nxt_s;
    logic [W-1:0]    lapt_nxt_s;
    logic [W-1:0]    best_nxt_s;
    logic            best_valid_nxt_s;
    logic [CW-1:0]   lap_count_nxt_s;
    logic [CW-1:0]   view_nxt_s;
    logic            overflow_nxt_s;
    logic            lap_full_nxt_s;
    logic [W-1:0]    show_nxt_s;
    logic            lap_we_s;
    logic            tick_s;
    cmd_t            cmd_s;

    // Pick the single highest-priority command pulse; the rest are dropped.
    always_comb begin
        cmd_s = CMD_NONE;
        if (clear) begin
            cmd_s = CMD_CLEAR;
        end else if (stop) begin
            cmd_s = CMD_STOP;
        end else if (start) begin
            cmd_s = CMD_START;
        end else if (lap) begin
            cmd_s = CMD_LAP;
        end else if (recall) begin
            cmd_s = CMD_RECALL;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Next-state, counting and display-mux logic.
    always_comb begin
        state_nxt_s      = state_r;
        presc_nxt_s      = presc_r;
        total_nxt_s      = total_r;
        lapt_nxt_s       = lapt_r;
        best_nxt_s       = best_r;
        best_valid_nxt_s = best_valid_r;
        lap_count_nxt_s  = lap_count_r;
        view_nxt_s       = view_r;
        overflow_nxt_s   = overflow_r;
        lap_we_s         = 1'b0;
        tick_s           = (state_r == ST_RUNNING) && (presc_r == PRE_MAX);

        // Time base runs only while RUNNING; it is frozen elsewhere so that a
        // resumed run keeps its sub-tick fraction.
        if (state_r == ST_RUNNING) begin
            presc_nxt_s = tick_s ? PRE_ZRO : (presc_r + PRE_ONE);
            if (tick_s) begin
                total_nxt_s = bcd_inc(total_r);
                lapt_nxt_s  = bcd_inc(lapt_r);
                if (bcd_all9(total_r)) begin
                    overflow_nxt_s = 1'b1;
                end else begin
                    overflow_nxt_s = overflow_r;
                end
            end else begin
                total_nxt_s = total_r;
            end
        end else begin
            presc_nxt_s = presc_r;
        end

        case (state_r)
            ST_IDLE: begin
                case (cmd_s)
                    CMD_START: state_nxt_s = ST_RUNNING;
                    CMD_CLEAR: begin
                        total_nxt_s      = BCD_ZRO;
                        lapt_nxt_s       = BCD_ZRO;
                        presc_nxt_s      = PRE_ZRO;
                        overflow_nxt_s   = 1'b0;
                        lap_count_nxt_s  = CNT_ZRO;
                        best_valid_nxt_s = 1'b0;
                        best_nxt_s       = BCD_ZRO;
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            ST_RUNNING: begin
                case (cmd_s)
                    CMD_STOP: state_nxt_s = ST_STOPPED;
                    CMD_LAP: begin
                        // A full buffer ignores the lap and lapt keeps counting.
                        if (lap_count_r != LAPS_C) begin
                            lap_we_s        = 1'b1;
                            lap_count_nxt_s = lap_count_r + CNT_ONE;
                            if (!best_valid_r || (lapt_r < best_r)) begin
                                best_nxt_s       = lapt_r;
                                best_valid_nxt_s = 1'b1;
                            end else begin
                                best_nxt_s       = best_r;
                            end
                            // Zeroed even when a tick lands on this edge.
                            lapt_nxt_s = BCD_ZRO;
                        end else begin
                            lap_we_s = 1'b0;
                        end
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            ST_STOPPED: begin
                case (cmd_s)
                    CMD_START: state_nxt_s = ST_RUNNING;
                    CMD_CLEAR: begin
                        state_nxt_s    = ST_IDLE;
                        total_nxt_s    = BCD_ZRO;
                        lapt_nxt_s     = BCD_ZRO;
                        presc_nxt_s    = PRE_ZRO;
                        overflow_nxt_s = 1'b0;
                    end
                    CMD_RECALL: begin
                        if (lap_count_r != CNT_ZRO) begin
                            state_nxt_s = ST_RECALL;
                            view_nxt_s  = CNT_ZRO;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            ST_RECALL: begin
                case (cmd_s)
                    CMD_STOP: begin
                        state_nxt_s = ST_STOPPED;
                        view_nxt_s  = CNT_ZRO;
                    end
                    CMD_START: begin
                        state_nxt_s = ST_RUNNING;
                        view_nxt_s  = CNT_ZRO;
                    end
                    CMD_CLEAR: begin
                        state_nxt_s    = ST_IDLE;
                        view_nxt_s     = CNT_ZRO;
                        total_nxt_s    = BCD_ZRO;
                        lapt_nxt_s     = BCD_ZRO;
                        presc_nxt_s    = PRE_ZRO;
                        overflow_nxt_s = 1'b0;
                    end
                    CMD_RECALL: begin
                        // Walk the stored laps, then the best entry, then leave.
                        if (view_r == LAPS_C) begin
                            state_nxt_s = ST_STOPPED;
                            view_nxt_s  = CNT_ZRO;
                        end else if (view_r == (lap_count_r - CNT_ONE)) begin
                            view_nxt_s  = LAPS_C;
                        end else begin
                            view_nxt_s  = view_r + CNT_ONE;
                        end
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        lap_full_nxt_s = (lap_count_nxt_s == LAPS_C);

        if (state_nxt_s == ST_RECALL) begin
            if (view_nxt_s == LAPS_C) begin
                show_nxt_s = best_nxt_s;
            end else begin
                show_nxt_s = buf_r[view_nxt_s[IW-1:0]];
            end
        end else begin
            show_nxt_s = total_nxt_s;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            presc_r      <= PRE_ZRO;
            total_r      <= BCD_ZRO;
            lapt_r       <= BCD_ZRO;
            best_r       <= BCD_ZRO;
            best_valid_r <= 1'b0;
            lap_count_r  <= CNT_ZRO;
            view_r       <= CNT_ZRO;
            overflow_r   <= 1'b0;
            lap_full_r   <= 1'b0;
            show_r       <= BCD_ZRO;
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= BCD_ZRO;
            end
        end else begin
            state_r      <= state_nxt_s;
            presc_r      <= presc_nxt_s;
            total_r      <= total_nxt_s;
            lapt_r       <= lapt_nxt_s;
            best_r       <= best_nxt_s;
            best_valid_r <= best_valid_nxt_s;
            lap_count_r  <= lap_count_nxt_s;
            view_r       <= view_nxt_s;
            overflow_r   <= overflow_nxt_s;
            lap_full_r   <= lap_full_nxt_s;
            show_r       <= show_nxt_s;
            if (lap_we_s) begin
                buf_r[lap_count_r[IW-1:0]] <= lapt_r;
            end else begin
                buf_r[lap_count_r[IW-1:0]] <= buf_r[lap_count_r[IW-1:0]];
            end
        end
    end

    assign show       = show_r;
    assign state      = state_r;
    assign lap_count  = lap_count_r;
    assign view_idx   = view_r;
    assign best_valid = best_valid_r;
    assign lap_full   = lap_full_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Testbench for lap_stopwatch with DIGITS=2, LAPS=2, TICK_DIV=4.
// Directed scenario tasks check against hand-derived constants; a random
// phase checks every output against an integer-level reference model.

module tb_lap_stopwatch;

    localparam int DIGITS   = 2;
    localparam int LAPS     = 2;
    localparam int TICK_DIV = 4;
    localparam int W        = 4 * DIGITS;
    localparam int CW       = $clog2(LAPS + 1);
    localparam int MAXV     = 99;

    logic          clock;
    logic          reset;
    logic          start;
    logic          stop;
    logic          lap;
    logic          recall;
    logic          clear;
    logic [W-1:0]  show;
    logic [1:0]    state;
    logic [CW-1:0] lap_count;
    logic [CW-1:0] view_idx;
    logic          best_valid;
    logic          lap_full;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers and a queue of lap durations.
    int m_state;
    int m_presc;
    int m_total;
    int m_lapt;
    int m_best;
    int m_bv;
    int m_ovf;
    int m_view;
    int m_laps[$];

    lap_stopwatch #(.DIGITS(DIGITS), .LAPS(LAPS), .TICK_DIV(TICK_DIV)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .lap(lap),
        .recall(recall), .clear(clear), .show(show), .state(state),
        .lap_count(lap_count), .view_idx(view_idx), .best_valid(best_valid),
        .lap_full(lap_full), .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        int v;
        r = '0;
        v = n;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_step(input logic s, input logic p, input logic l,
                              input logic r, input logic c, input logic rs);
        int cmd;
        int old_lapt;
        bit tick;
        if (rs) begin
            m_state = 0; m_presc = 0; m_total = 0; m_lapt = 0;
            m_best = 0; m_bv = 0; m_ovf = 0; m_view = 0;
            m_laps.delete();
            return;
        end
        old_lapt = m_lapt;
        tick = (m_state == 1) && (m_presc == TICK_DIV - 1);
        if (m_state == 1) m_presc = tick ? 0 : m_presc + 1;
        if (tick) begin
            if (m_total == MAXV) m_ovf = 1; else m_total = m_total + 1;
            if (m_lapt < MAXV) m_lapt = m_lapt + 1;
        end
        // 1 clear, 2 stop, 3 start, 4 lap, 5 recall
        cmd = c ? 1 : p ? 2 : s ? 3 : l ? 4 : r ? 5 : 0;
        case (m_state)
            0: begin
                if (cmd == 3) m_state = 1;
                if (cmd == 1) begin
                    m_total = 0; m_lapt = 0; m_presc = 0; m_ovf = 0;
                    m_laps.delete(); m_bv = 0; m_best = 0;
                end
            end
            1: begin
                if (cmd == 2) m_state = 2;
                if (cmd == 4 && m_laps.size() < LAPS) begin
                    m_laps.push_back(old_lapt);
                    if (!m_bv || old_lapt < m_best) begin
                        m_best = old_lapt;
                        m_bv = 1;
                    end
                    m_lapt = 0;
                end
            end
            2: begin
                if (cmd == 3) m_state = 1;
                if (cmd == 1) begin
                    m_state = 0; m_total = 0; m_lapt = 0; m_presc = 0; m_ovf = 0;
                end
                if (cmd == 5 && m_laps.size() > 0) begin
                    m_state = 3; m_view = 0;
                end
            end
            default: begin
                if (cmd == 2) begin m_state = 2; m_view = 0; end
                if (cmd == 3) begin m_state = 1; m_view = 0; end
                if (cmd == 1) begin
                    m_state = 0; m_view = 0;
                    m_total = 0; m_lapt = 0; m_presc = 0; m_ovf = 0;
                end
                if (cmd == 5) begin
                    if (m_view == LAPS) begin
                        m_state = 2; m_view = 0;
                    end else if (m_view == m_laps.size() - 1) begin
                        m_view = LAPS;
                    end else begin
                        m_view = m_view + 1;
                    end
                end
            end
        endcase
    endtask

    // One clock: drive pulses (start, stop, lap, recall, clear, reset), step the
    // model at the edge, then sample point is 1 time unit after the edge.
    task automatic cycle(input logic s, input logic p, input logic l,
                         input logic r, input logic c, input logic rs);
        start = s; stop = p; lap = l; recall = r; clear = c; reset = rs;
        @(posedge clock);
        model_step(s, p, l, r, c, rs);
        #1;
        start = 1'b0; stop = 1'b0; lap = 1'b0; recall = 1'b0; clear = 1'b0; reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (show !== 8'h00) begin $display("FAIL reset_show: got %h want 00", show); errors++; end
        checks++;
        if ({state, lap_count, view_idx, best_valid, lap_full, overflow} !== 9'd0) begin
            $display("FAIL reset_flags: state=%0d lc=%0d vi=%0d bv=%b lf=%b ov=%b want all 0",
                     state, lap_count, view_idx, best_valid, lap_full, overflow);
            errors++;
        end
    endtask

    task automatic test_count_carry;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(40);
        checks++;
        if (show !== 8'h10) begin $display("FAIL count_show: got %h want 10", show); errors++; end
        checks++;
        if (state !== 2'd1) begin $display("FAIL count_state: got %0d want 1", state); errors++; end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        checks++;
        if (show !== 8'h10 || state !== 2'd2) begin
            $display("FAIL stopped_hold: show=%h state=%0d want 10/2", show, state); errors++;
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (show !== 8'h00 || state !== 2'd0) begin
            $display("FAIL clear_stopped: show=%h state=%0d want 00/0", show, state); errors++;
        end
    endtask

    task automatic test_fraction;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (show !== 8'h01) begin $display("FAIL frac_stop_show: got %h want 01", show); errors++; end
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (show !== 8'h01) begin $display("FAIL frac_early: got %h want 01", show); errors++; end
        idle(1);
        checks++;
        if (show !== 8'h02) begin $display("FAIL frac_tick: got %h want 02", show); errors++; end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_laps_best;
        logic [W-1:0] want [3];
        want[0] = 8'h05; want[1] = 8'h03; want[2] = 8'h03;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lap_count !== 2'd2 || lap_full !== 1'b1 || best_valid !== 1'b1) begin
            $display("FAIL laps_two: lc=%0d lf=%b bv=%b want 2/1/1", lap_count, lap_full, best_valid);
            errors++;
        end
        idle(3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lap_count !== 2'd2) begin $display("FAIL lap_third: lc=%0d want 2", lap_count); errors++; end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (show !== want[i] || state !== 2'd3) begin
                $display("FAIL recall_%0d: show=%h state=%0d want %h/3", i, show, state, want[i]);
                errors++;
            end
        end
        checks++;
        if (view_idx !== 2'd2) begin $display("FAIL recall_best_idx: got %0d want 2", view_idx); errors++; end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd2 || view_idx !== 2'd0) begin
            $display("FAIL recall_exit: state=%0d vi=%0d want 2/0", state, view_idx); errors++;
        end
    endtask

    task automatic test_simultaneous;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(7);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (show !== 8'h02 || lap_count !== 2'd1) begin
            $display("FAIL lap_tick: show=%h lc=%0d want 02/1", show, lap_count); errors++;
        end
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd2) begin $display("FAIL stop_start: state=%0d want 2", state); errors++; end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (show !== 8'h01) begin $display("FAIL lap_tick_stored: got %h want 01", show); errors++; end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (show !== 8'h01) begin $display("FAIL lapt_zeroed: got %h want 01", show); errors++; end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd2) begin $display("FAIL recall_empty: state=%0d want 2", state); errors++; end
    endtask

    task automatic test_saturation;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(420);
        checks++;
        if (show !== 8'h99 || overflow !== 1'b1) begin
            $display("FAIL saturate: show=%h ov=%b want 99/1", show, overflow); errors++;
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (show !== 8'h00 || overflow !== 1'b0 || lap_count !== 2'd1 || state !== 2'd0) begin
            $display("FAIL sat_clear1: show=%h ov=%b lc=%0d st=%0d want 00/0/1/0",
                     show, overflow, lap_count, state);
            errors++;
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_count !== 2'd0 || best_valid !== 1'b0) begin
            $display("FAIL sat_clear2: lc=%0d bv=%b want 0/0", lap_count, best_valid); errors++;
        end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd3) begin $display("FAIL mid_recall: state=%0d want 3", state); errors++; end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({show, state, lap_count, view_idx, best_valid, lap_full, overflow} !== 17'd0) begin
            $display("FAIL mid_reset: show=%h state=%0d lc=%0d vi=%0d bv=%b lf=%b ov=%b want all 0",
                     show, state, lap_count, view_idx, best_valid, lap_full, overflow);
            errors++;
        end
    endtask

    task automatic test_random;
        logic [16:0] got;
        logic [16:0] exp;
        logic [W-1:0] exp_show;
        int bad;
        bad = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 299) == 0));
            if (m_state == 3)
                exp_show = to_bcd(m_view == LAPS ? m_best : m_laps[m_view]);
            else
                exp_show = to_bcd(m_total);
            exp = {exp_show, 2'(m_state), CW'(m_laps.size()), CW'(m_view), 1'(m_bv),
                   1'(m_laps.size() == LAPS), 1'(m_ovf)};
            got = {show, state, lap_count, view_idx, best_valid, lap_full, overflow};
            checks++;
            if (got !== exp) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cycle_%0d: got %h want %h", i, got, exp);
                bad++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0; recall = 1'b0; clear = 1'b0;
        #1;
        test_reset();
        test_count_carry();
        test_fraction();
        test_laps_best();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
